// File: rtl/fuart_if.sv
// fuart_if: UART host-side and serial signals shared by fuart and its users
interface fuart_if #(parameter int DATA_BITS = 8);
  logic [15:0] div;
  logic [1:0] parity;
  logic stop2, rx, tx, wr, tx_full, tx_empty, busy;
  logic rd, valid, rx_perr, rx_ferr, overrun, clr_overrun;
  logic [DATA_BITS-1:0] tx_data, rx_data;
  modport master (
    output div, parity, stop2, rx, wr, tx_data, rd, clr_overrun,
    input  tx, tx_full, tx_empty, busy, rx_data, valid, rx_perr, rx_ferr, overrun
  );
  modport slave (
    input  div, parity, stop2, rx, wr, tx_data, rd, clr_overrun,
    output tx, tx_full, tx_empty, busy, rx_data, valid, rx_perr, rx_ferr, overrun
  );
endinterface

// File: rtl/fuart.sv
// fuart: FIFO-buffered UART transmitter and receiver with per-frame latched div/parity/stop settings
module fuart #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  fuart_if.slave u
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DATA_BITS + 2;
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4;
  logic [DATA_BITS-1:0] tmem [FIFO_DEPTH];
  logic [AW:0] twp, trp;
  logic [2:0] ts;
  logic [15:0] tcnt, tdiv;
  logic [DATA_BITS-1:0] tsh, thead;
  logic [3:0] tbi;
  logic tpbit, tpen, ts2, tsc, tpush, tend, tload;
  assign u.tx_empty = twp == trp;
  assign u.tx_full = (twp[AW] != trp[AW]) && (twp[AW-1:0] == trp[AW-1:0]);
  assign tpush = u.wr && !u.tx_full;
  assign tend = tcnt == 16'd0;
  assign thead = tmem[trp[AW-1:0]];
  // a new frame starts from IDLE or straight out of the final stop bit period
  assign tload = !u.tx_empty && (ts == S_IDLE || (ts == S_STOP && tend && !tsc));
  assign u.busy = ts != S_IDLE;
  assign u.tx = ts == S_START ? 1'b0 : ts == S_DATA ? tsh[0] : ts == S_PAR ? tpbit : 1'b1;
  always_ff @(posedge clk)
    if (tpush) tmem[twp[AW-1:0]] <= u.tx_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      twp <= '0;
      trp <= '0;
    end else begin
      twp <= twp + {{AW{1'b0}}, tpush};
      trp <= trp + {{AW{1'b0}}, tload};
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= S_IDLE;
      tcnt <= '0;
      tdiv <= '0;
      tsh <= '0;
      tbi <= '0;
      tpbit <= 1'b0;
      tpen <= 1'b0;
      ts2 <= 1'b0;
      tsc <= 1'b0;
    end else if (tload) begin
      ts <= S_START;
      tcnt <= u.div - 16'd1;
      tdiv <= u.div;
      tsh <= thead;
      tpbit <= ^thead ^ (u.parity == 2'b10);
      tpen <= u.parity == 2'b01 || u.parity == 2'b10;
      ts2 <= u.stop2;
    end else if (ts != S_IDLE) begin
      if (!tend) tcnt <= tcnt - 16'd1;
      else begin
        tcnt <= tdiv - 16'd1;
        case (ts)
          S_START: begin
            ts <= S_DATA;
            tbi <= '0;
          end
          S_DATA: begin
            tsh <= tsh >> 1;
            tbi <= tbi + 4'd1;
            tsc <= ts2;
            if (tbi == LAST) ts <= tpen ? S_PAR : S_STOP;
          end
          S_PAR: ts <= S_STOP;
          S_STOP: begin
            tsc <= 1'b0;
            if (!tsc) ts <= S_IDLE;
          end
          default: ts <= S_IDLE;
        endcase
      end
    end
  logic [SYNC_STAGES-1:0] sync;
  logic rs, rs_d;
  assign rs = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '1;
      rs_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], u.rx};
      rs_d <= rs;
    end
  logic [DW-1:0] rmem [FIFO_DEPTH];
  logic [AW:0] rwp, rrp;
  logic [2:0] rst;
  logic [15:0] rcnt, rdiv;
  logic [DATA_BITS-1:0] rsh;
  logic [3:0] rbi;
  logic rpen, rodd, rperr, rdone, rempty, rfull, rpush, rpop, ovr;
  assign rempty = rwp == rrp;
  assign rfull = (rwp[AW] != rrp[AW]) && (rwp[AW-1:0] == rrp[AW-1:0]);
  assign rdone = rst == S_STOP && rcnt == 16'd0;
  assign rpush = rdone && !rfull;
  assign rpop = u.rd && !rempty;
  assign u.valid = !rempty;
  assign {u.rx_perr, u.rx_ferr, u.rx_data} = rmem[rrp[AW-1:0]];
  assign u.overrun = ovr;
  always_ff @(posedge clk)
    if (rpush) rmem[rwp[AW-1:0]] <= {rperr, !rs, rsh};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rwp <= '0;
      rrp <= '0;
      ovr <= 1'b0;
    end else begin
      rwp <= rwp + {{AW{1'b0}}, rpush};
      rrp <= rrp + {{AW{1'b0}}, rpop};
      ovr <= (rdone && rfull) || (ovr && !u.clr_overrun);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rst <= S_IDLE;
      rcnt <= '0;
      rdiv <= '0;
      rsh <= '0;
      rbi <= '0;
      rpen <= 1'b0;
      rodd <= 1'b0;
      rperr <= 1'b0;
    end else if (rst == S_IDLE) begin
      if (rs_d && !rs) begin
        rst <= S_START;
        rcnt <= u.div >> 1;
        rdiv <= u.div;
        rpen <= u.parity == 2'b01 || u.parity == 2'b10;
        rodd <= u.parity == 2'b10;
        rperr <= 1'b0;
      end
    end else if (rcnt != 16'd0) rcnt <= rcnt - 16'd1;
    else begin
      rcnt <= rdiv - 16'd1;
      case (rst)
        S_START: begin
          rst <= rs ? S_IDLE : S_DATA;
          rbi <= '0;
        end
        S_DATA: begin
          rsh <= {rs, rsh[DATA_BITS-1:1]};
          rbi <= rbi + 4'd1;
          if (rbi == LAST) rst <= rpen ? S_PAR : S_STOP;
        end
        S_PAR: begin
          rperr <= ^rsh ^ rs ^ rodd;
          rst <= S_STOP;
        end
        default: rst <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fuart.sv
// tb_fuart: directed and randomized checks of fuart against a bit-list frame model
module tb_fuart;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  fuart_if #(.DATA_BITS(8)) bus();
  logic loop = 1'b0, rx_drv = 1'b1;
  assign bus.rx = loop ? bus.tx : rx_drv;
  fuart #(.DATA_BITS(8), .FIFO_DEPTH(D), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .u(bus));
  int checks = 0, failures = 0;
  logic [7:0] wq[$];
  logic [9:0] mq[$];
  bit movr = 1'b0;
  bit eb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void frame(input logic [7:0] d, input logic [1:0] p, input bit s2, input int dv, input bit flip, input bit stopb);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (p == 2'b01 || p == 2'b10) b.push_back(($countones(d) % 2 == 1) ^ (p == 2'b10) ^ flip);
    b.push_back(stopb);
    if (s2) b.push_back(1'b1);
    foreach (b[k]) repeat (dv) eb.push_back(b[k]);
  endfunction
  task automatic tx_run(input int nwr, input int dv, input logic [1:0] p, input bit s2);
    int nacc, fr, mt, mb;
    logic full_cap;
    nacc = nwr < D + 1 ? nwr : D + 1;
    mt = 0;
    mb = 0;
    full_cap = 1'bx;
    eb.delete();
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    for (int k = 0; k < nacc; k++) frame(wq[k], p, s2, dv, 1'b0, 1'b1);
    fr = eb.size() - 2;
    repeat (3 * dv) eb.push_back(1'b1);
    bus.div = 16'(dv);
    bus.parity = p;
    bus.stop2 = s2;
    for (int i = 0; i < eb.size(); i++) begin
      @(negedge clk);
      if (bus.tx !== eb[i]) mt++;
      if (bus.busy !== (i >= 2 && i < 2 + fr)) mb++;
      if (i == D + 1) full_cap = bus.tx_full;
      bus.wr = i < nwr;
      bus.tx_data = i < nwr ? wq[i] : 8'h00;
      if (i == 2 + dv && nacc == 1) begin
        bus.div = 16'(dv + 3);
        bus.parity = ~p;
        bus.stop2 = ~s2;
      end
    end
    bus.wr = 1'b0;
    chk("tx_wave", mt, 0);
    chk("tx_busy", mb, 0);
    chk("tx_empty_end", bus.tx_empty, 1'b1);
    if (nwr > D + 1) chk("tx_full_at_cap", full_cap, 1'b1);
    wq.delete();
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic [1:0] p, input bit flip, input bit stopb, input int dv);
    eb.delete();
    frame(d, p, 1'b0, dv, flip, stopb);
    repeat (2 * dv) eb.push_back(1'b1);
    bus.div = 16'(dv);
    bus.parity = p;
    foreach (eb[i]) begin
      @(negedge clk);
      rx_drv = eb[i];
    end
    if (mq.size() < D) mq.push_back({flip && (p == 2'b01 || p == 2'b10), !stopb, d});
    else movr = 1'b1;
  endtask
  task automatic drain();
    logic [9:0] e;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      chk("rx_valid", bus.valid, 1'b1);
      chk("rx_entry", {bus.rx_perr, bus.rx_ferr, bus.rx_data}, e);
      @(negedge clk) bus.rd = 1'b1;
      @(negedge clk) bus.rd = 1'b0;
    end
    chk("rx_empty", bus.valid, 1'b0);
  endtask
  initial begin
    logic [7:0] rd8;
    logic [1:0] rp;
    bit rs2;
    int rdv;
    bus.div = 16'd8;
    bus.parity = 2'b00;
    bus.stop2 = 1'b0;
    bus.wr = 1'b0;
    bus.tx_data = 8'h00;
    bus.rd = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_tx_empty", bus.tx_empty, 1'b1);
    chk("rst_tx_full", bus.tx_full, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    wq.push_back(8'hA5);
    tx_run(1, 8, 2'b00, 1'b0);
    loop = 1'b1;
    wq.push_back(8'h07);
    tx_run(1, 8, 2'b01, 1'b0);
    mq.push_back({2'b00, 8'h07});
    wq.push_back(8'h07);
    tx_run(1, 8, 2'b10, 1'b0);
    mq.push_back({2'b00, 8'h07});
    drain();
    loop = 1'b0;
    rx_frame(8'h07, 2'b01, 1'b1, 1'b1, 8);
    drain();
    repeat (6) begin
      rd8 = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rs2 = 1'($urandom_range(0, 1));
      rdv = $urandom_range(4, 12);
      loop = 1'b1;
      wq.push_back(rd8);
      tx_run(1, rdv, rp, rs2);
      mq.push_back({2'b00, rd8});
      drain();
    end
    loop = 1'b0;
    wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    tx_run(6, 4, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) rx_frame(8'($urandom), 2'b00, 1'b0, 1'b1, 8);
    chk("ovr_valid", bus.valid, 1'b1);
    chk("ovr_set", bus.overrun, movr);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", bus.overrun, 1'b1);
    bus.clr_overrun = 1'b1;
    @(negedge clk) bus.clr_overrun = 1'b0;
    chk("ovr_clr", bus.overrun, 1'b0);
    movr = 1'b0;
    drain();
    bus.div = 16'd16;
    @(negedge clk) rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("false_start", bus.valid, 1'b0);
    rx_frame(8'h3C, 2'b00, 1'b0, 1'b0, 16);
    drain();
    loop = 1'b1;
    wq.push_back(8'h5A);
    tx_run(1, 8, 2'b00, 1'b0);
    chk("pre_rst_valid", bus.valid, 1'b1);
    bus.tx_data = 8'hFF;
    bus.wr = 1'b1;
    @(negedge clk) bus.wr = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_tx", bus.tx, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_valid", bus.valid, 1'b0);
    chk("arst_tx_empty", bus.tx_empty, 1'b1);
    mq.delete();
    @(negedge clk) reset = 1'b0;
    wq.push_back(8'hC3);
    tx_run(1, 8, 2'b00, 1'b0);
    mq.push_back({2'b00, 8'hC3});
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
